// File: rtl/e203_subsys_console_arb.sv
// Two-master ICB arbiter for the console target: round-robin grant, one outstanding transaction.
// Define E203_CONSOLE_ARB_STATS_EN to build the saturating per-master grant counters.
module e203_subsys_console_arb #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       m_icb_cmd_valid,
    output logic [1:0]       m_icb_cmd_ready,
    input  logic [63:0]      m_icb_cmd_addr,
    input  logic [1:0]       m_icb_cmd_read,
    input  logic [63:0]      m_icb_cmd_wdata,
    input  logic [7:0]       m_icb_cmd_wmask,
    output logic [1:0]       m_icb_rsp_valid,
    input  logic [1:0]       m_icb_rsp_ready,
    output logic [1:0]       m_icb_rsp_err,
    output logic [1:0]       m_icb_rsp_excl_ok,
    output logic [63:0]      m_icb_rsp_rdata,
    output logic             t_icb_cmd_valid,
    input  logic             t_icb_cmd_ready,
    output logic [31:0]      t_icb_cmd_addr,
    output logic             t_icb_cmd_read,
    output logic [31:0]      t_icb_cmd_wdata,
    output logic [3:0]       t_icb_cmd_wmask,
    input  logic             t_icb_rsp_valid,
    output logic             t_icb_rsp_ready,
    input  logic             t_icb_rsp_err,
    input  logic             t_icb_rsp_excl_ok,
    input  logic [31:0]      t_icb_rsp_rdata,
    output logic             spurious_rsp_o,
    output logic [CNT_W-1:0] grant_cnt0_o,
    output logic [CNT_W-1:0] grant_cnt1_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state_q;
    logic   prio_q;
    logic   owner_q;
    logic   lock_q;
    logic   lock_mst_q;
    logic   spurious_q;

    logic   busy;
    logic   grant;
    logic   cmd_hs;
    logic   rsp_route;
    logic   rsp_sel;
    logic   rsp_hs;

    assign busy = (state_q == BUSY);

    // A stalled command keeps its master so the target sees a stable request.
    always_comb begin
        grant = 1'b0;
        if (lock_q && m_icb_cmd_valid[lock_mst_q])
            grant = lock_mst_q;
        else if (&m_icb_cmd_valid)
            grant = prio_q;
        else
            grant = m_icb_cmd_valid[1];
    end

    assign t_icb_cmd_valid = ~busy & (|m_icb_cmd_valid);
    assign t_icb_cmd_addr  = m_icb_cmd_addr[{grant, 5'b0} +: 32];
    assign t_icb_cmd_wdata = m_icb_cmd_wdata[{grant, 5'b0} +: 32];
    assign t_icb_cmd_wmask = m_icb_cmd_wmask[{grant, 2'b0} +: 4];
    assign t_icb_cmd_read  = m_icb_cmd_read[grant];

    always_comb begin
        m_icb_cmd_ready = 2'b00;
        if (!busy)
            m_icb_cmd_ready[grant] = t_icb_cmd_ready;
    end

    assign cmd_hs    = t_icb_cmd_valid & t_icb_cmd_ready;
    assign rsp_route = busy | cmd_hs;
    assign rsp_sel   = busy ? owner_q : grant;

    // Unowned responses are swallowed so a stray target pulse cannot stall the bus.
    assign t_icb_rsp_ready = rsp_route ? m_icb_rsp_ready[rsp_sel] : 1'b1;
    assign rsp_hs          = t_icb_rsp_valid & t_icb_rsp_ready;

    always_comb begin
        m_icb_rsp_valid   = 2'b00;
        m_icb_rsp_err     = 2'b00;
        m_icb_rsp_excl_ok = 2'b00;
        m_icb_rsp_rdata   = 64'd0;
        if (rsp_route) begin
            m_icb_rsp_valid[rsp_sel]               = t_icb_rsp_valid;
            m_icb_rsp_err[rsp_sel]                 = t_icb_rsp_err;
            m_icb_rsp_excl_ok[rsp_sel]             = t_icb_rsp_excl_ok;
            m_icb_rsp_rdata[{rsp_sel, 5'b0} +: 32] = t_icb_rsp_rdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            lock_q     <= 1'b0;
            lock_mst_q <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    lock_q     <= t_icb_cmd_valid & ~t_icb_cmd_ready;
                    lock_mst_q <= grant;
                    if (cmd_hs) begin
                        owner_q <= grant;
                        prio_q  <= ~grant;
                        if (!rsp_hs)
                            state_q <= BUSY;
                    end else if (t_icb_rsp_valid) begin
                        spurious_q <= 1'b1;
                    end
                end
                BUSY: begin
                    lock_q <= 1'b0;
                    if (rsp_hs)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spurious_rsp_o = spurious_q;

`ifdef E203_CONSOLE_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (cmd_hs) begin
            if (!grant && !(&cnt0_q))
                cnt0_q <= cnt0_q + 1'b1;
            if (grant && !(&cnt1_q))
                cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign grant_cnt0_o = cnt0_q;
    assign grant_cnt1_o = cnt1_q;
`else
    assign grant_cnt0_o = '0;
    assign grant_cnt1_o = '0;
`endif

endmodule

// File: tb/tb_e203_subsys_console_arb.sv
// Bench for e203_subsys_console_arb: directed scenarios, then randomized traffic against a
// transaction-level target model with per-master response scoreboards.
module tb_e203_subsys_console_arb;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic        read;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } cmd_t;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [1:0]       m_icb_cmd_valid;
    logic [1:0]       m_icb_cmd_ready;
    logic [63:0]      m_icb_cmd_addr;
    logic [1:0]       m_icb_cmd_read;
    logic [63:0]      m_icb_cmd_wdata;
    logic [7:0]       m_icb_cmd_wmask;
    logic [1:0]       m_icb_rsp_valid;
    logic [1:0]       m_icb_rsp_ready;
    logic [1:0]       m_icb_rsp_err;
    logic [1:0]       m_icb_rsp_excl_ok;
    logic [63:0]      m_icb_rsp_rdata;
    logic             t_icb_cmd_valid;
    logic             t_icb_cmd_ready;
    logic [31:0]      t_icb_cmd_addr;
    logic             t_icb_cmd_read;
    logic [31:0]      t_icb_cmd_wdata;
    logic [3:0]       t_icb_cmd_wmask;
    logic             t_icb_rsp_valid;
    logic             t_icb_rsp_ready;
    logic             t_icb_rsp_err;
    logic             t_icb_rsp_excl_ok;
    logic [31:0]      t_icb_rsp_rdata;
    logic             spurious_rsp_o;
    logic [CNT_W-1:0] grant_cnt0_o;
    logic [CNT_W-1:0] grant_cnt1_o;

    e203_subsys_console_arb #(.CNT_W(CNT_W)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .m_icb_cmd_valid   (m_icb_cmd_valid),
        .m_icb_cmd_ready   (m_icb_cmd_ready),
        .m_icb_cmd_addr    (m_icb_cmd_addr),
        .m_icb_cmd_read    (m_icb_cmd_read),
        .m_icb_cmd_wdata   (m_icb_cmd_wdata),
        .m_icb_cmd_wmask   (m_icb_cmd_wmask),
        .m_icb_rsp_valid   (m_icb_rsp_valid),
        .m_icb_rsp_ready   (m_icb_rsp_ready),
        .m_icb_rsp_err     (m_icb_rsp_err),
        .m_icb_rsp_excl_ok (m_icb_rsp_excl_ok),
        .m_icb_rsp_rdata   (m_icb_rsp_rdata),
        .t_icb_cmd_valid   (t_icb_cmd_valid),
        .t_icb_cmd_ready   (t_icb_cmd_ready),
        .t_icb_cmd_addr    (t_icb_cmd_addr),
        .t_icb_cmd_read    (t_icb_cmd_read),
        .t_icb_cmd_wdata   (t_icb_cmd_wdata),
        .t_icb_cmd_wmask   (t_icb_cmd_wmask),
        .t_icb_rsp_valid   (t_icb_rsp_valid),
        .t_icb_rsp_ready   (t_icb_rsp_ready),
        .t_icb_rsp_err     (t_icb_rsp_err),
        .t_icb_rsp_excl_ok (t_icb_rsp_excl_ok),
        .t_icb_rsp_rdata   (t_icb_rsp_rdata),
        .spurious_rsp_o    (spurious_rsp_o),
        .grant_cnt0_o      (grant_cnt0_o),
        .grant_cnt1_o      (grant_cnt1_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Random-phase state: master requests, target model, scoreboards.
    bit          rand_on = 1'b0;
    logic [1:0]  pend;
    cmd_t        mc [2];
    bit          tgt_busy;
    int          tgt_delay;
    cmd_t        tgt_cmd;
    cmd_t        exp_cmd [$];
    logic [33:0] exp_rsp0 [$];
    logic [33:0] exp_rsp1 [$];
    int          hs_cnt [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Target behaviour: response content is a fixed function of the command it served.
    function automatic logic [33:0] tgt_resp(input cmd_t c);
        logic [31:0] rd;
        rd = c.read ? ((c.addr ^ 32'hC0DE_0000) + 32'd7) : ~c.wdata;
        return {c.addr[2] ^ c.wmask[1], c.addr[4], rd};
    endfunction

    task automatic clear_inputs();
        m_icb_cmd_valid   = 2'b00;
        m_icb_cmd_addr    = 64'd0;
        m_icb_cmd_read    = 2'b00;
        m_icb_cmd_wdata   = 64'd0;
        m_icb_cmd_wmask   = 8'h00;
        m_icb_rsp_ready   = 2'b00;
        t_icb_cmd_ready   = 1'b0;
        t_icb_rsp_valid   = 1'b0;
        t_icb_rsp_err     = 1'b0;
        t_icb_rsp_excl_ok = 1'b0;
        t_icb_rsp_rdata   = 32'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycle(input bit allow_new);
        cmd_t cur;
        step();
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && allow_new && $urandom_range(0, 2) == 0) begin
                pend[i]     = 1'b1;
                mc[i].addr  = $urandom;
                mc[i].read  = 1'($urandom_range(0, 1));
                mc[i].wdata = $urandom;
                mc[i].wmask = 4'($urandom);
            end
        end
        m_icb_cmd_valid = pend;
        m_icb_cmd_addr  = {mc[1].addr, mc[0].addr};
        m_icb_cmd_read  = {mc[1].read, mc[0].read};
        m_icb_cmd_wdata = {mc[1].wdata, mc[0].wdata};
        m_icb_cmd_wmask = {mc[1].wmask, mc[0].wmask};
        t_icb_cmd_ready = ($urandom_range(0, 3) != 0);
        m_icb_rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
        #1;
        cur = '{t_icb_cmd_addr, t_icb_cmd_read, t_icb_cmd_wdata, t_icb_cmd_wmask};
        if (tgt_busy && tgt_delay == 0) begin
            t_icb_rsp_valid = 1'b1;
            {t_icb_rsp_err, t_icb_rsp_excl_ok, t_icb_rsp_rdata} = tgt_resp(tgt_cmd);
        end else if (!tgt_busy && t_icb_cmd_valid && t_icb_cmd_ready && $urandom_range(0, 2) == 0) begin
            t_icb_rsp_valid = 1'b1;
            {t_icb_rsp_err, t_icb_rsp_excl_ok, t_icb_rsp_rdata} = tgt_resp(cur);
        end else begin
            t_icb_rsp_valid   = 1'b0;
            t_icb_rsp_err     = 1'($urandom_range(0, 1));
            t_icb_rsp_excl_ok = 1'($urandom_range(0, 1));
            t_icb_rsp_rdata   = $urandom;
        end
    endtask

    // Monitor: pushes expectations on master-side acceptance, pops on target/master delivery.
    always @(negedge clk) begin
        if (rand_on) begin
            logic [1:0]  chs;
            logic [33:0] er;
            cmd_t        ec;
            cmd_t        cur;
            bit          tcmd_hs;
            bit          trsp_hs;
            chs = m_icb_cmd_valid & m_icb_cmd_ready;
            if (chs != 2'b00)
                check("cmd_ready_onehot", 64'($countones(chs)), 64'd1);
            for (int i = 0; i < 2; i++) begin
                if (chs[i]) begin
                    exp_cmd.push_back(mc[i]);
                    if (i == 0) exp_rsp0.push_back(tgt_resp(mc[i]));
                    else        exp_rsp1.push_back(tgt_resp(mc[i]));
                    hs_cnt[i]++;
                    pend[i] = 1'b0;
                end
            end
            if (tgt_busy)
                check("t_cmd_valid_while_outstanding", 64'(t_icb_cmd_valid), 64'd0);
            cur     = '{t_icb_cmd_addr, t_icb_cmd_read, t_icb_cmd_wdata, t_icb_cmd_wmask};
            tcmd_hs = t_icb_cmd_valid && t_icb_cmd_ready;
            trsp_hs = t_icb_rsp_valid && t_icb_rsp_ready;
            if (tcmd_hs) begin
                if (exp_cmd.size() == 0) begin
                    check("t_cmd_unexpected", 64'd1, 64'(exp_cmd.size()));
                end else begin
                    ec = exp_cmd.pop_front();
                    check("t_cmd_addr", 64'(cur.addr), 64'(ec.addr));
                    check("t_cmd_wdata", 64'(cur.wdata), 64'(ec.wdata));
                    check("t_cmd_read_wmask", 64'({cur.read, cur.wmask}), 64'({ec.read, ec.wmask}));
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (m_icb_rsp_valid[i] && m_icb_rsp_ready[i]) begin
                    if ((i == 0 && exp_rsp0.size() == 0) || (i == 1 && exp_rsp1.size() == 0)) begin
                        check($sformatf("m%0d_rsp_unexpected", i), 64'd1, 64'd0);
                    end else begin
                        er = (i == 0) ? exp_rsp0.pop_front() : exp_rsp1.pop_front();
                        check($sformatf("m%0d_rsp_fields", i),
                              64'({m_icb_rsp_err[i], m_icb_rsp_excl_ok[i], m_icb_rsp_rdata[i*32 +: 32]}),
                              64'(er));
                    end
                    check($sformatf("m%0d_rsp_nonowner_quiet", 1 - i),
                          64'({m_icb_rsp_valid[1-i], m_icb_rsp_rdata[(1-i)*32 +: 32]}), 64'd0);
                end
            end
            if (tgt_busy) begin
                if (trsp_hs) tgt_busy = 1'b0;
                else if (tgt_delay > 0) tgt_delay--;
            end else if (tcmd_hs) begin
                if (t_icb_rsp_valid) begin
                    if (!trsp_hs) begin
                        tgt_busy  = 1'b1;
                        tgt_cmd   = cur;
                        tgt_delay = 0;
                    end
                end else begin
                    tgt_busy  = 1'b1;
                    tgt_cmd   = cur;
                    tgt_delay = $urandom_range(0, 3);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CNT_W-1:0] e0, e1;
        bit               stuck;
        clear_inputs();
        rst_i = 1'b1;
        pend  = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_t_cmd_valid", 64'(t_icb_cmd_valid), 64'd0);
        check("rst_m_rsp_valid", 64'(m_icb_rsp_valid), 64'd0);
        check("rst_spurious", 64'(spurious_rsp_o), 64'd0);
        check("rst_counters", 64'({grant_cnt1_o, grant_cnt0_o}), 64'd0);
        check("rst_t_rsp_ready", 64'(t_icb_rsp_ready), 64'd1);
        step();
        rst_i = 1'b0;

        // Master0 write with same-cycle response.
        m_icb_cmd_valid = 2'b01;
        m_icb_cmd_addr  = {32'h0, 32'h4};
        m_icb_cmd_wdata = {32'h0, 32'h41};
        m_icb_cmd_wmask = 8'h0F;
        t_icb_cmd_ready = 1'b1;
        t_icb_rsp_valid = 1'b1;
        m_icb_rsp_ready = 2'b11;
        @(negedge clk);
        check("w41_t_cmd_valid", 64'(t_icb_cmd_valid), 64'd1);
        check("w41_t_cmd_addr", 64'(t_icb_cmd_addr), 64'h4);
        check("w41_t_cmd_wdata", 64'(t_icb_cmd_wdata), 64'h41);
        check("w41_m_cmd_ready", 64'(m_icb_cmd_ready), 64'b01);
        check("w41_m_rsp_valid", 64'(m_icb_rsp_valid), 64'b01);
        step();
        m_icb_cmd_valid = 2'b10;
        m_icb_cmd_addr  = {32'h10, 32'h4};
        @(negedge clk);
        check("w41_still_idle_ready", 64'(m_icb_cmd_ready), 64'b10);
        check("w41_m1_rsp_valid", 64'(m_icb_rsp_valid), 64'b10);
        check("w41_no_spurious", 64'(spurious_rsp_o), 64'd0);

        // Both masters continuously requesting: alternation from master0.
        do_reset();
        m_icb_cmd_valid = 2'b11;
        m_icb_cmd_addr  = {32'h200, 32'h100};
        t_icb_cmd_ready = 1'b1;
        t_icb_rsp_valid = 1'b1;
        m_icb_rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rr_ready_%0d", k), 64'(m_icb_cmd_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
            check($sformatf("rr_addr_%0d", k), 64'(t_icb_cmd_addr), (k % 2 == 0) ? 64'h100 : 64'h200);
            step();
        end
        m_icb_cmd_valid = 2'b00;
        t_icb_rsp_valid = 1'b0;
        @(negedge clk);
`ifdef E203_CONSOLE_ARB_STATS_EN
        check("rr_cnt0", 64'(grant_cnt0_o), 64'd2);
        check("rr_cnt1", 64'(grant_cnt1_o), 64'd2);
`else
        check("rr_cnt0", 64'(grant_cnt0_o), 64'd0);
        check("rr_cnt1", 64'(grant_cnt1_o), 64'd0);
`endif

        // Grant lock while the target stalls master1.
        do_reset();
        m_icb_cmd_valid = 2'b10;
        m_icb_cmd_addr  = {32'h300, 32'h30};
        @(negedge clk);
        check("lock_c1_addr", 64'(t_icb_cmd_addr), 64'h300);
        check("lock_c1_ready", 64'(m_icb_cmd_ready), 64'b00);
        step();
        m_icb_cmd_valid = 2'b11;
        @(negedge clk);
        check("lock_c2_addr", 64'(t_icb_cmd_addr), 64'h300);
        step();
        @(negedge clk);
        check("lock_c3_addr", 64'(t_icb_cmd_addr), 64'h300);
        step();
        t_icb_cmd_ready = 1'b1;
        t_icb_rsp_valid = 1'b1;
        m_icb_rsp_ready = 2'b11;
        @(negedge clk);
        check("lock_hs_ready", 64'(m_icb_cmd_ready), 64'b10);
        step();
        @(negedge clk);
        check("lock_next_m0", 64'(m_icb_cmd_ready), 64'b01);

        // Master0 read with a delayed response, master1 held off while busy.
        do_reset();
        m_icb_cmd_valid = 2'b01;
        m_icb_cmd_addr  = {32'h80, 32'h8};
        m_icb_cmd_read  = 2'b01;
        t_icb_cmd_ready = 1'b1;
        @(negedge clk);
        check("rd_hs_ready", 64'(m_icb_cmd_ready), 64'b01);
        step();
        m_icb_cmd_valid = 2'b11;
        @(negedge clk);
        check("rd_busy1_ready", 64'(m_icb_cmd_ready), 64'b00);
        check("rd_busy1_tvalid", 64'(t_icb_cmd_valid), 64'd0);
        check("rd_busy1_rsp", 64'(m_icb_rsp_valid), 64'b00);
        step();
        @(negedge clk);
        check("rd_busy2_ready", 64'(m_icb_cmd_ready), 64'b00);
        step();
        t_icb_rsp_valid = 1'b1;
        t_icb_rsp_rdata = 32'h0;
        m_icb_rsp_ready = 2'b10;
        @(negedge clk);
        check("rd_bp_rsp_valid", 64'(m_icb_rsp_valid), 64'b01);
        check("rd_bp_t_rsp_ready", 64'(t_icb_rsp_ready), 64'd0);
        step();
        m_icb_rsp_ready = 2'b11;
        @(negedge clk);
        check("rd_rsp_valid", 64'(m_icb_rsp_valid), 64'b01);
        check("rd_rsp_data", 64'(m_icb_rsp_rdata), 64'd0);
        check("rd_t_rsp_ready", 64'(t_icb_rsp_ready), 64'd1);
        step();
        t_icb_rsp_valid = 1'b0;
        @(negedge clk);
        check("rd_after_m1", 64'(m_icb_cmd_ready), 64'b10);

        // Spurious response and reset in the middle of a transaction.
        do_reset();
        t_icb_rsp_valid = 1'b1;
        @(negedge clk);
        check("sp_t_rsp_ready", 64'(t_icb_rsp_ready), 64'd1);
        check("sp_dropped", 64'(m_icb_rsp_valid), 64'b00);
        check("sp_not_yet", 64'(spurious_rsp_o), 64'd0);
        step();
        t_icb_rsp_valid = 1'b0;
        @(negedge clk);
        check("sp_set", 64'(spurious_rsp_o), 64'd1);
        step();
        @(negedge clk);
        check("sp_sticky", 64'(spurious_rsp_o), 64'd1);
        step();
        m_icb_cmd_valid = 2'b01;
        t_icb_cmd_ready = 1'b1;
        @(negedge clk);
        check("sp_cmd_hs", 64'(m_icb_cmd_ready), 64'b01);
        step();
        m_icb_cmd_valid = 2'b00;
        rst_i           = 1'b1;
        t_icb_rsp_valid = 1'b1;
        t_icb_rsp_rdata = 32'h55;
        m_icb_rsp_ready = 2'b11;
        @(negedge clk);
        check("sp_rst_flag", 64'(spurious_rsp_o), 64'd0);
        check("sp_rst_rsp", 64'(m_icb_rsp_valid), 64'b00);
        step();
        rst_i = 1'b0;
        @(negedge clk);
        check("sp_post_rst_rsp", 64'(m_icb_rsp_valid), 64'b00);
        check("sp_post_rst_idle", 64'(t_icb_rsp_ready), 64'd1);
        step();
        t_icb_rsp_valid = 1'b0;

        // Randomized traffic.
        do_reset();
        pend      = 2'b00;
        tgt_busy  = 1'b0;
        tgt_delay = 0;
        hs_cnt[0] = 0;
        hs_cnt[1] = 0;
        rand_on   = 1'b1;
        for (int n = 0; n < 3000; n++)
            rand_cycle(1'b1);
        stuck = 1'b1;
        for (int n = 0; n < 300 && stuck; n++) begin
            rand_cycle(1'b0);
            @(negedge clk);
            #1;
            stuck = (pend != 2'b00) || tgt_busy || exp_cmd.size() != 0 ||
                    exp_rsp0.size() != 0 || exp_rsp1.size() != 0;
        end
        rand_on = 1'b0;
        check("drain_timeout", 64'(stuck), 64'd0);
        check("rand_rsp_left", 64'(exp_rsp0.size() + exp_rsp1.size()), 64'd0);
        check("rand_no_spurious", 64'(spurious_rsp_o), 64'd0);
`ifdef E203_CONSOLE_ARB_STATS_EN
        e0 = CNT_W'(hs_cnt[0]);
        e1 = CNT_W'(hs_cnt[1]);
`else
        e0 = '0;
        e1 = '0;
`endif
        check("rand_cnt0", 64'(grant_cnt0_o), 64'(e0));
        check("rand_cnt1", 64'(grant_cnt1_o), 64'(e1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
